// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO controller: register addresses, default IDs
// and the byte-enable expansion helper.
package gpio_pkg;

  localparam int NUM_PINS_MAX = 32;

  localparam logic [31:0] CHIP_NAME_DEFAULT    = 32'h48524a44;
  localparam logic [31:0] CHIP_VERSION_DEFAULT = 32'h00000002;

  localparam logic [3:0] ADDR_NAME       = 4'd0;
  localparam logic [3:0] ADDR_VERSION    = 4'd1;
  localparam logic [3:0] ADDR_OE         = 4'd2;
  localparam logic [3:0] ADDR_PINSTATE   = 4'd3;
  localparam logic [3:0] ADDR_IRQ_MASK   = 4'd4;
  localparam logic [3:0] ADDR_DATA       = 4'd5;
  localparam logic [3:0] ADDR_SCRATCH    = 4'd6;
  localparam logic [3:0] ADDR_RISE_EN    = 4'd7;
  localparam logic [3:0] ADDR_FALL_EN    = 4'd8;
  localparam logic [3:0] ADDR_IRQ_STATUS = 4'd9;
  localparam logic [3:0] ADDR_DATA_SET   = 4'd10;
  localparam logic [3:0] ADDR_DATA_CLR   = 4'd11;

  function automatic logic [31:0] byte_mask(input logic [3:0] wben);
    return {{8{wben[3]}}, {8{wben[2]}}, {8{wben[1]}}, {8{wben[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser chain plus one-cycle edge history; produces the
// synchronised pin state and the enabled rise/fall event vector.
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int NUM_PINS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_PINS-1:0] gpio_in,
  input  logic [NUM_PINS-1:0] rise_en,
  input  logic [NUM_PINS-1:0] fall_en,
  output logic [NUM_PINS-1:0] s,
  output logic [NUM_PINS-1:0] ev
);

  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] p;

  // The history register tracks s regardless of the enables, so turning an
  // enable on never sees a stale previous value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      p <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      p <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s  = sync_q[SYNC_STAGES-1];
  assign ev = (s & ~p & rise_en) | (~s & p & fall_en);

endmodule

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO controller: bus register file, atomic set/clear of the
// output data, sticky W1C interrupt status and a registered masked irq.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int          NUM_PINS     = 16,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] CHIP_NAME    = CHIP_NAME_DEFAULT,
  parameter logic [31:0] CHIP_VERSION = CHIP_VERSION_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel,
  input  logic [5:2]          addr,
  input  logic [3:0]          wben,
  input  logic                r_wn,
  input  logic [31:0]         wdata,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [31:0]         rdata,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);

  logic                wr, rd;
  logic [31:0]         bm, scratch, rd_mux;
  logic [NUM_PINS-1:0] pin_bm, pin_wd, w1c;
  logic [NUM_PINS-1:0] irq_mask, rise_en, fall_en, status, s, ev;

  assign wr     = sel & ~r_wn;
  assign rd     = sel & r_wn;
  assign bm     = byte_mask(wben);
  assign pin_bm = bm[NUM_PINS-1:0];
  assign pin_wd = wdata[NUM_PINS-1:0] & pin_bm;
  assign w1c    = (wr && addr == ADDR_IRQ_STATUS) ? pin_wd : '0;

  gpio_sync_edge #(
    .NUM_PINS   (NUM_PINS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .gpio_in(gpio_in),
    .rise_en(rise_en),
    .fall_en(fall_en),
    .s      (s),
    .ev     (ev)
  );

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_NAME:       rd_mux = CHIP_NAME;
      ADDR_VERSION:    rd_mux = CHIP_VERSION;
      ADDR_OE:         rd_mux = 32'(gpio_oe);
      ADDR_PINSTATE:   rd_mux = 32'(s);
      ADDR_IRQ_MASK:   rd_mux = 32'(irq_mask);
      ADDR_DATA:       rd_mux = 32'(gpio_out);
      ADDR_SCRATCH:    rd_mux = scratch;
      ADDR_RISE_EN:    rd_mux = 32'(rise_en);
      ADDR_FALL_EN:    rd_mux = 32'(fall_en);
      ADDR_IRQ_STATUS: rd_mux = 32'(status);
      default:         rd_mux = '0;
    endcase
  end

  // Events are OR-ed in after the W1C mask so a coincident event wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata    <= '0;
      gpio_out <= '0;
      gpio_oe  <= '0;
      irq_mask <= '0;
      scratch  <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      irq      <= 1'b0;
    end else begin
      status <= (status & ~w1c) | ev;
      irq    <= |(status & irq_mask);
      if (rd) rdata <= rd_mux;
      if (wr) begin
        case (addr)
          ADDR_OE:       gpio_oe  <= (gpio_oe  & ~pin_bm) | pin_wd;
          ADDR_IRQ_MASK: irq_mask <= (irq_mask & ~pin_bm) | pin_wd;
          ADDR_DATA:     gpio_out <= (gpio_out & ~pin_bm) | pin_wd;
          ADDR_SCRATCH:  scratch  <= (scratch  & ~bm) | (wdata & bm);
          ADDR_RISE_EN:  rise_en  <= (rise_en  & ~pin_bm) | pin_wd;
          ADDR_FALL_EN:  fall_en  <= (fall_en  & ~pin_bm) | pin_wd;
          ADDR_DATA_SET: gpio_out <= gpio_out | pin_wd;
          ADDR_DATA_CLR: gpio_out <= gpio_out & ~pin_wd;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Parametrised GPIO controller that succeeds the fixed 16-pin GPIO register block. It is a memory-mapped register file on the peripheral bus, with these pin-facing functions:
- configurable pin count
- input synchronisation
- per-pin rising/falling edge detection
- sticky write-1-to-clear interrupt status
- atomic set/clear of output data
- a single masked interrupt line to the core

Parameters:
NUM_PINS, 16, GPIO pin count, legal range 1..32.
SYNC_STAGES, 2, input synchroniser depth, legal range 2..4.
CHIP_NAME, 32'h48524a44, value returned by the NAME register.
CHIP_VERSION, 32'h00000002, value returned by VERSION; bytes are Major, Minor, Bugfix, Development.

Ports:
clk  input  1  master clock; all state is on its rising edge.
reset  input  1  asynchronous, active-low reset (assert when 0).
sel  input  1  bus access strobe; one access per cycle while high.
addr  input  [5:2]  word address of the register.
wben  input  4  write byte enables.
r_wn  input  1  1 = read, 0 = write; qualified by sel.
wdata  input  32  write data.
gpio_in  input  NUM_PINS  raw asynchronous pin state.
rdata  output  32  read data.
gpio_out  output  NUM_PINS  output data register.
gpio_oe  output  NUM_PINS  output enable (tristate register); 1 = pin driven.
irq  output  1  registered interrupt request.

Behaviour:
- Reset (reset == 0, asynchronous): all of the following are 0: rdata, gpio_out, gpio_oe, irq, all RW registers, the status register, the synchroniser chain and the edge history.
- Access: a read or write occurs only when sel = 1.
- Read latency: rdata is updated on the clock edge of sel & r_wn and is valid the following cycle. rdata holds its value otherwise.
- Unmapped addresses (0xC..0xF) read 0; writes to them are ignored.
- Register map (word address: name, access):
  - 0: NAME, RO
  - 1: VERSION, RO
  - 2: OE, RW (drives gpio_oe)
  - 3: PINSTATE, RO (synchronised gpio_in)
  - 4: IRQ_MASK, RW
  - 5: DATA, RW (drives gpio_out)
  - 6: SCRATCH, RW, full 32 bits
  - 7: RISE_EN, RW
  - 8: FALL_EN, RW
  - 9: IRQ_STATUS, W1C
  - 10: DATA_SET, WO, reads 0
  - 11: DATA_CLR, WO, reads 0
- Width rules:
  - Pin registers are NUM_PINS wide and read back zero-extended to 32 bits.
  - wben[k] gates wdata[8k+7:8k] onto register bits [8k+7:8k] that exist; bits at or above NUM_PINS are dropped.
  - The same wben masking applies to the W1C, SET and CLR registers: only enabled bytes take effect.
- DATA_SET: DATA |= wdata. DATA_CLR: DATA &= ~wdata. Both are single-cycle and atomic.
- Synchroniser: gpio_in passes through SYNC_STAGES flops to give s. PINSTATE = s.
- Edge history: p = s delayed by one cycle.
- Event vector: ev = (s & ~p & RISE_EN) | (~s & p & FALL_EN).
- Latency: a pin edge sets its status bit SYNC_STAGES+1 cycles after the input transition. irq follows one further cycle later.
- Status update: status_next = (status & ~w1c_mask) | ev. If an event and a W1C hit the same bit in the same cycle, the event wins and the bit stays 1.
- irq is registered: irq <= |(status & IRQ_MASK).
  - Masking does not clear status.
  - Unmasking a pending bit raises irq on the next cycle.
- Read/write ordering: a read of IRQ_STATUS returns the pre-edge value. A read never clears status.
- Enable-change spurious edges: enabling RISE_EN/FALL_EN does not create a spurious event, because p is always tracking.
- After reset release: p = s = 0, so a pin already high at release produces one rising event (if enabled) after synchronisation.

Decomposition:
- Package gpio_pkg:
  - address constants ADDR_NAME..ADDR_DATA_CLR (4-bit)
  - default CHIP_NAME / CHIP_VERSION constants
  - NUM_PINS_MAX = 32
- Sub-module gpio_sync_edge:
  - Parameters NUM_PINS and SYNC_STAGES.
  - Inputs gpio_in, RISE_EN, FALL_EN.
  - Outputs s and ev.
  - Instantiated once.
- The top level holds the register file, the W1C/SET/CLR logic and irq.

Test Plan:
- Reset and ID: hold reset = 0 mid-traffic, then release; read addr 0, 1, 2 -> rdata 0x48524a44, 0x00000002, 0x0 one cycle after each sel; irq = 0 and gpio_out = 0.
- Byte-enable writes (NUM_PINS = 16):
  - Write DATA = 0xFFFFA5C3 with wben = 4'b0001 -> gpio_out = 0x00C3.
  - Then DATA_SET 0x0100 -> 0x01C3.
  - Then DATA_CLR 0x0003 -> 0x01C0.
  - Read DATA -> 0x000001C0.
- Rising-edge interrupt:
  - Setup: RISE_EN = 0x0004, IRQ_MASK = 0x0004.
  - Drive gpio_in[2] 0->1 -> IRQ_STATUS = 0x4 after 3 cycles; irq = 1 one cycle later.
  - W1C 0x4 -> status 0, and irq = 0 on the following cycle.
- W1C collision:
  - Setup: FALL_EN = 0x1, status bit 0 pending.
  - Time a new falling edge on pin 0 to coincide with a W1C 0x1 -> status bit 0 remains 1.
- Mask gating and width: with NUM_PINS = 8, write IRQ_MASK = 0xFFFF -> reads 0x000000FF; a pending status with mask 0 gives irq = 0; setting the mask bit gives irq = 1 next cycle.
- Async reset mid-operation: assert reset between edges while irq = 1 -> irq, status and gpio_oe drop to 0 immediately, with no clock required.
